// File: rtl/map_table_pkg.sv
// Shared constants and types for the register map table (arch reg -> ROB tag renaming).
package map_table_pkg;

    localparam int unsigned REG_LEN = 32;
    localparam int unsigned ROB_LEN = 8;
    localparam int unsigned TAG_W   = $clog2(ROB_LEN) + 1;
    localparam int unsigned IDX_W   = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ready;
    } MT_ENTRY;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] dest_idx;
        logic [TAG_W-1:0] tag;
    } ROB2MT_PACKET;

    typedef struct packed {
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_ready;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_ready;
    } MT2RS_PACKET;

endpackage

// File: rtl/map_table_if.sv
// Dispatch / CDB / retire / lookup signal bundle for the map table.
interface map_table_if;
    import map_table_pkg::*;

    logic             squash;
    logic             disp_valid;
    logic [IDX_W-1:0] disp_rs1_idx;
    logic [IDX_W-1:0] disp_rs2_idx;
    logic [IDX_W-1:0] disp_dest_idx;
    logic [TAG_W-1:0] disp_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             ret_valid;
    logic [IDX_W-1:0] ret_dest_idx;
    logic [TAG_W-1:0] ret_tag;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_ready;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_ready;

    modport master (
        output squash, disp_valid, disp_rs1_idx, disp_rs2_idx, disp_dest_idx, disp_tag,
        output cdb_valid, cdb_tag, ret_valid, ret_dest_idx, ret_tag,
        input  rs1_tag, rs1_ready, rs2_tag, rs2_ready
    );

    modport slave (
        input  squash, disp_valid, disp_rs1_idx, disp_rs2_idx, disp_dest_idx, disp_tag,
        input  cdb_valid, cdb_tag, ret_valid, ret_dest_idx, ret_tag,
        output rs1_tag, rs1_ready, rs2_tag, rs2_ready
    );

endinterface

// File: rtl/map_table_entry.sv
// One architectural register's mapping: {tag, ready}, priority write > clear > cdb set.
module map_table_entry
    import map_table_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_write,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_clear,
    input  logic             i_cdb_hit,
    output MT_ENTRY          o_entry
);

    MT_ENTRY r_entry;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_entry <= '0;
        end else if (i_write) begin
            // A fresh mapping is never ready, even if its tag is on the CDB this cycle.
            r_entry.tag   <= i_wr_tag;
            r_entry.ready <= 1'b0;
        end else if (i_clear) begin
            r_entry <= '0;
        end else if (i_cdb_hit) begin
            r_entry.ready <= 1'b1;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/map_table.sv
// Register map table: renames arch regs to ROB tags. Define MT_CDB_FWD_EN for same-cycle
// CDB forwarding into the ready outputs.
module map_table
    import map_table_pkg::*;
(
    input logic        clock,
    input logic        reset,
    map_table_if.slave bus
);

    MT_ENTRY      w_entries [REG_LEN];
    ROB2MT_PACKET w_ret;
    MT2RS_PACKET  w_rs;
    MT_ENTRY      w_e1;
    MT_ENTRY      w_e2;
    logic         w_disp_ok;
    logic         w_cdb_ok;
    logic         w_fwd1;
    logic         w_fwd2;

    // Squash wins over dispatch, so a dispatch in the squash cycle is dropped here.
    assign w_disp_ok = bus.disp_valid && (bus.disp_tag != '0) && !bus.squash;
    assign w_cdb_ok  = bus.cdb_valid && (bus.cdb_tag != '0);

    assign w_ret.valid    = bus.ret_valid && (bus.ret_tag != '0);
    assign w_ret.dest_idx = bus.ret_dest_idx;
    assign w_ret.tag      = bus.ret_tag;

    assign w_entries[0] = '0;

    for (genvar gi = 1; gi < REG_LEN; gi++) begin : g_entry
        MT_ENTRY w_cur;
        logic    w_write;
        logic    w_clear;
        logic    w_cdb_hit;

        assign w_write   = w_disp_ok && (bus.disp_dest_idx == IDX_W'(gi));
        // Retire only clears when no newer instruction has remapped the register.
        assign w_clear   = bus.squash ||
                           (w_ret.valid && (w_ret.dest_idx == IDX_W'(gi)) &&
                            (w_cur.tag == w_ret.tag));
        assign w_cdb_hit = w_cdb_ok && (w_cur.tag == bus.cdb_tag);

        map_table_entry u_entry (
            .clock     (clock),
            .reset     (reset),
            .i_write   (w_write),
            .i_wr_tag  (bus.disp_tag),
            .i_clear   (w_clear),
            .i_cdb_hit (w_cdb_hit),
            .o_entry   (w_cur)
        );

        assign w_entries[gi] = w_cur;
    end

    assign w_e1 = w_entries[bus.disp_rs1_idx];
    assign w_e2 = w_entries[bus.disp_rs2_idx];

`ifdef MT_CDB_FWD_EN
    assign w_fwd1 = w_cdb_ok && (bus.cdb_tag == w_e1.tag);
    assign w_fwd2 = w_cdb_ok && (bus.cdb_tag == w_e2.tag);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    always_comb begin
        w_rs           = '0;
        w_rs.rs1_tag   = w_e1.tag;
        w_rs.rs1_ready = (w_e1.tag != '0) && (w_e1.ready || w_fwd1);
        w_rs.rs2_tag   = w_e2.tag;
        w_rs.rs2_ready = (w_e2.tag != '0) && (w_e2.ready || w_fwd2);
    end

    assign bus.rs1_tag   = w_rs.rs1_tag;
    assign bus.rs1_ready = w_rs.rs1_ready;
    assign bus.rs2_tag   = w_rs.rs2_tag;
    assign bus.rs2_ready = w_rs.rs2_ready;

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios plus randomized traffic vs. array model.
module tb_map_table;

`ifdef MT_CDB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [3:0] m_tag [32];
    logic       m_rdy [32];

    map_table_if bus ();

    map_table dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic set_idle();
        bus.squash        = 1'b0;
        bus.disp_valid    = 1'b0;
        bus.disp_rs1_idx  = '0;
        bus.disp_rs2_idx  = '0;
        bus.disp_dest_idx = '0;
        bus.disp_tag      = '0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_tag       = '0;
        bus.ret_valid     = 1'b0;
        bus.ret_dest_idx  = '0;
        bus.ret_tag       = '0;
    endtask

    task automatic dispatch(input int dest, input int tag);
        bus.disp_valid    = 1'b1;
        bus.disp_dest_idx = 5'(dest);
        bus.disp_tag      = 4'(tag);
    endtask

    // Reference: apply the table's update rules to the model at the clock edge.
    task automatic apply_edge();
        logic [3:0] nt [32];
        logic       nr [32];
        @(posedge clock);
        for (int r = 0; r < 32; r++) begin
            nt[r] = m_tag[r];
            nr[r] = m_rdy[r];
        end
        if (reset || bus.squash) begin
            for (int r = 0; r < 32; r++) begin
                nt[r] = 0;
                nr[r] = 0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (bus.disp_valid && bus.disp_tag != 0 && bus.disp_dest_idx == 5'(r)) begin
                    nt[r] = bus.disp_tag;
                    nr[r] = 0;
                end else if (bus.ret_valid && bus.ret_tag != 0 && bus.ret_dest_idx == 5'(r) &&
                             m_tag[r] == bus.ret_tag) begin
                    nt[r] = 0;
                    nr[r] = 0;
                end else if (bus.cdb_valid && bus.cdb_tag != 0 && m_tag[r] == bus.cdb_tag) begin
                    nr[r] = 1;
                end
            end
        end
        for (int r = 0; r < 32; r++) begin
            m_tag[r] = nt[r];
            m_rdy[r] = nr[r];
        end
        #1;
    endtask

    function automatic logic [4:0] exp_look(input logic [4:0] idx);
        logic rdy;
        rdy = (m_tag[idx] != 0) &&
              (m_rdy[idx] || (FWD && bus.cdb_valid && bus.cdb_tag == m_tag[idx]));
        return {m_tag[idx], rdy};
    endfunction

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        apply_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        dispatch(5, 3);
        reset = 1'b1;
        apply_edge();
        reset = 1'b0;
        set_idle();
        bus.disp_rs1_idx = 5'd5;
        bus.disp_rs2_idx = 5'd7;
        #1;
        checks++;
        if ({bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready} !== 10'd0) begin
            errors++;
            $display("FAIL reset_lookup: got %0d/%0b %0d/%0b want 0/0 0/0",
                     bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready);
        end
    endtask

    task automatic test_dispatch_cdb();
        do_reset();
        dispatch(5, 3);
        bus.disp_rs1_idx = 5'd5;
        apply_edge();
        set_idle();
        bus.disp_rs1_idx = 5'd5;
        #1;
        checks++;
        if (bus.rs1_tag !== 4'd3 || bus.rs1_ready !== 1'b0) begin
            errors++;
            $display("FAIL disp_map: got %0d/%0b want 3/0", bus.rs1_tag, bus.rs1_ready);
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd3;
        #1;
        checks++;
        if (bus.rs1_ready !== FWD) begin
            errors++;
            $display("FAIL cdb_same_cycle: got ready %0b want %0b", bus.rs1_ready, FWD);
        end
        apply_edge();
        set_idle();
        bus.disp_rs1_idx = 5'd5;
        #1;
        checks++;
        if (bus.rs1_tag !== 4'd3 || bus.rs1_ready !== 1'b1) begin
            errors++;
            $display("FAIL cdb_ready: got %0d/%0b want 3/1", bus.rs1_tag, bus.rs1_ready);
        end
    endtask

    task automatic test_retire();
        do_reset();
        dispatch(5, 3);
        apply_edge();
        dispatch(5, 6);
        apply_edge();
        set_idle();
        bus.ret_valid    = 1'b1;
        bus.ret_dest_idx = 5'd5;
        bus.ret_tag      = 4'd3;
        apply_edge();
        set_idle();
        bus.disp_rs2_idx = 5'd5;
        #1;
        checks++;
        if (bus.rs2_tag !== 4'd6) begin
            errors++;
            $display("FAIL retire_stale: got tag %0d want 6", bus.rs2_tag);
        end
        bus.ret_valid    = 1'b1;
        bus.ret_dest_idx = 5'd5;
        bus.ret_tag      = 4'd6;
        apply_edge();
        set_idle();
        bus.disp_rs2_idx = 5'd5;
        #1;
        checks++;
        if (bus.rs2_tag !== 4'd0 || bus.rs2_ready !== 1'b0) begin
            errors++;
            $display("FAIL retire_match: got %0d/%0b want 0/0", bus.rs2_tag, bus.rs2_ready);
        end
    endtask

    task automatic test_rd_eq_rs();
        do_reset();
        dispatch(4, 7);
        apply_edge();
        dispatch(4, 2);
        bus.disp_rs1_idx = 5'd4;
        bus.disp_rs2_idx = 5'd4;
        #1;
        checks++;
        if (bus.rs1_tag !== 4'd7 || bus.rs2_tag !== 4'd7) begin
            errors++;
            $display("FAIL rd_eq_rs_old: got %0d,%0d want 7,7", bus.rs1_tag, bus.rs2_tag);
        end
        apply_edge();
        set_idle();
        bus.disp_rs1_idx = 5'd4;
        #1;
        checks++;
        if (bus.rs1_tag !== 4'd2 || bus.rs1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_eq_rs_new: got %0d/%0b want 2/0", bus.rs1_tag, bus.rs1_ready);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            dispatch(r, r);
            apply_edge();
        end
        set_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd2;
        apply_edge();
        set_idle();
        bus.squash = 1'b1;
        dispatch(9, 5);
        bus.cdb_valid    = 1'b1;
        bus.cdb_tag      = 4'd1;
        bus.ret_valid    = 1'b1;
        bus.ret_dest_idx = 5'd3;
        bus.ret_tag      = 4'd3;
        apply_edge();
        set_idle();
        for (int r = 1; r <= 9; r++) begin
            if (r <= 4 || r == 9) begin
                bus.disp_rs1_idx = 5'(r);
                #1;
                checks++;
                if (bus.rs1_tag !== 4'd0 || bus.rs1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL squash_reg%0d: got %0d/%0b want 0/0",
                             r, bus.rs1_tag, bus.rs1_ready);
                end
            end
        end
    endtask

    task automatic test_x0();
        do_reset();
        dispatch(0, 4);
        apply_edge();
        set_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd4;
        apply_edge();
        bus.disp_rs1_idx = 5'd0;
        bus.disp_rs2_idx = 5'd0;
        #1;
        checks++;
        if ({bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready} !== 10'd0) begin
            errors++;
            $display("FAIL x0_fixed: got %0d/%0b want 0/0", bus.rs1_tag, bus.rs1_ready);
        end
    endtask

    task automatic test_disp_cdb_collide();
        do_reset();
        dispatch(6, 3);
        apply_edge();
        set_idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd3;
        apply_edge();
        set_idle();
        dispatch(6, 5);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd5;
        apply_edge();
        set_idle();
        bus.disp_rs1_idx = 5'd6;
        #1;
        checks++;
        if (bus.rs1_tag !== 4'd5 || bus.rs1_ready !== 1'b0) begin
            errors++;
            $display("FAIL disp_cdb_collide: got %0d/%0b want 5/0", bus.rs1_tag, bus.rs1_ready);
        end
    endtask

    task automatic test_invalid_inputs();
        do_reset();
        dispatch(8, 2);
        apply_edge();
        set_idle();
        bus.disp_dest_idx = 5'd8;
        bus.disp_tag      = 4'd7;
        bus.cdb_tag       = 4'd2;
        bus.ret_dest_idx  = 5'd8;
        bus.ret_tag       = 4'd2;
        apply_edge();
        dispatch(8, 0);
        bus.ret_valid = 1'b1;
        bus.ret_tag   = 4'd0;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd0;
        apply_edge();
        set_idle();
        bus.disp_rs2_idx = 5'd8;
        #1;
        checks++;
        if (bus.rs2_tag !== 4'd2 || bus.rs2_ready !== 1'b0) begin
            errors++;
            $display("FAIL invalid_ignored: got %0d/%0b want 2/0", bus.rs2_tag, bus.rs2_ready);
        end
    endtask

    task automatic randomize_inputs(input bit allow_ctl);
        int pick;
        bus.squash        = allow_ctl && ($urandom_range(0, 31) == 0);
        bus.disp_valid    = $urandom_range(0, 3) != 0;
        bus.disp_rs1_idx  = 5'($urandom_range(0, 31));
        bus.disp_rs2_idx  = 5'($urandom_range(0, 31));
        bus.disp_dest_idx = 5'($urandom_range(0, 15));
        bus.disp_tag      = 4'($urandom_range(0, 8));
        bus.cdb_valid     = $urandom_range(0, 1) != 0;
        bus.cdb_tag       = 4'($urandom_range(0, 8));
        bus.ret_valid     = $urandom_range(0, 1) != 0;
        pick              = $urandom_range(0, 15);
        bus.ret_dest_idx  = 5'(pick);
        bus.ret_tag       = ($urandom_range(0, 1) != 0) ? m_tag[pick] : 4'($urandom_range(0, 8));
        reset             = allow_ctl && ($urandom_range(0, 63) == 0);
    endtask

    task automatic test_random();
        logic [4:0] e1;
        logic [4:0] e2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            randomize_inputs(1'b1);
            #1;
            e1 = exp_look(bus.disp_rs1_idx);
            e2 = exp_look(bus.disp_rs2_idx);
            checks++;
            if ({bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready} !== {e1, e2}) begin
                errors++;
                $display("FAIL random_lookup cycle %0d: got %0d/%0b %0d/%0b want %0d/%0b %0d/%0b",
                         n, bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready,
                         e1[4:1], e1[0], e2[4:1], e2[0]);
            end
            apply_edge();
        end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            randomize_inputs(1'b0);
            apply_edge();
        end
        randomize_inputs(1'b0);
        reset = 1'b1;
        apply_edge();
        reset = 1'b0;
        set_idle();
        for (int r = 0; r < 32; r++) begin
            bus.disp_rs1_idx = 5'(r);
            bus.disp_rs2_idx = 5'(31 - r);
            #1;
            checks++;
            if ({bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready} !== 10'd0) begin
                errors++;
                $display("FAIL mid_reset_reg%0d: got %0d/%0b %0d/%0b want 0/0 0/0",
                         r, bus.rs1_tag, bus.rs1_ready, bus.rs2_tag, bus.rs2_ready);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int r = 0; r < 32; r++) begin
            m_tag[r] = 0;
            m_rdy[r] = 0;
        end
        reset = 1'b1;
        set_idle();
        apply_edge();
        apply_edge();
        reset = 1'b0;

        test_reset();
        test_dispatch_cdb();
        test_retire();
        test_rd_eq_rs();
        test_squash();
        test_x0();
        test_disp_cdb_collide();
        test_invalid_inputs();
        test_random();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameters (name, default, meaning):
- REG_LEN, 32, architectural registers.
- ROB_LEN, 8, ROB entries.
- TAG_W, $clog2(ROB_LEN)+1, tag width; tag 0 = "value in register file", ROB tags run 1..ROB_LEN.

REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- squash  in  1  flush all speculative mappings.
- disp_valid  in  1  dispatch this cycle.
- disp_rs1_idx  in  5  source 1 arch reg.
- disp_rs2_idx  in  5  source 2 arch reg.
- disp_dest_idx  in  5  dest arch reg; 0 = no dest.
- disp_tag  in  TAG_W  ROB tag allocated to dispatching instr.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  completing ROB tag.
- ret_valid  in  1  ROB head retiring.
- ret_dest_idx  in  5  retiring dest arch reg.
- ret_tag  in  TAG_W  retiring ROB tag.
- rs1_tag  out  TAG_W  mapping of disp_rs1_idx.
- rs1_ready  out  1  rs1_tag's value already in ROB.
- rs2_tag  out  TAG_W  mapping of disp_rs2_idx.
- rs2_ready  out  1  rs2_tag's value already in ROB.

Function
REQ-003 State: per arch reg, {tag[TAG_W], ready}; entry 0 (x0) SHALL permanently hold tag 0, ready 0.
REQ-004 Lookup SHALL be combinational on registered state: rsN_tag = entry[idx].tag, rsN_ready = entry[idx].ready; tag 0 SHALL always give ready 0.
REQ-005 Dispatch (disp_valid, disp_dest_idx!=0) SHALL write {disp_tag, 0} into entry[disp_dest_idx] at next edge; same-cycle lookup of that reg SHALL return the old mapping (rd==rs handled correctly).
REQ-006 CDB: each entry with tag==cdb_tag (nonzero) SHALL set ready at next edge.
REQ-007 Retire: if entry[ret_dest_idx].tag==ret_tag, entry SHALL clear to {0,0} at next edge; on mismatch (newer mapping) entry SHALL be untouched.
REQ-008 Priority per entry: squash > dispatch write > retire clear > CDB set.
REQ-009 Dispatch and CDB on same entry same cycle: written entry SHALL hold ready 0.
REQ-010 Squash SHALL clear every entry to {0,0} at next edge, ignoring all other inputs that cycle.
REQ-011 Inputs with valid low SHALL have no effect; disp_tag, cdb_tag, ret_tag of 0 SHALL be ignored.

Reset
REQ-012 reset SHALL clear every entry to {0,0} at next edge, overriding all inputs; outputs then read tag 0, ready 0.
REQ-013 reset asserted mid-stream SHALL discard all mappings with no residual ready bits.

Configuration
REQ-014 MT_CDB_FWD_EN defined: rsN_ready SHALL also assert combinationally when cdb_valid and cdb_tag equals the looked-up nonzero tag (same-cycle forwarding).
REQ-015 MT_CDB_FWD_EN undefined: rsN_ready SHALL reflect registered state only (one-cycle-later visibility).

Structure
REQ-016 Shared package SHALL hold REG_LEN, ROB_LEN, TAG_W, MT_ENTRY struct {tag, ready}, and ROB2MT / MT2RS packet typedefs.
REQ-017 Per-register storage SHALL be sub-module map_table_entry (inputs: write, clear, cdb hit; output: MT_ENTRY), instantiated REG_LEN-1 times.

Verification
REQ-018 Reset, then lookup rs1=5, rs2=7 -> tags 0/0, ready 0/0.
REQ-019 Dispatch dest=5, tag=3; next cycle lookup rs1=5 -> tag 3, ready 0; cdb tag 3 -> following cycle ready 1 (with MT_CDB_FWD_EN: ready 1 in CDB cycle).
REQ-020 Dispatch dest=5 tag=3, later dest=5 tag=6; retire reg 5 tag 3 -> entry stays tag 6; retire tag 6 -> tag 0.
REQ-021 Same cycle: dispatch dest=4 tag=2, lookup rs1=4 -> returns old tag; next cycle tag 2.
REQ-022 Map regs 1..4 to tags 1..4, assert squash with simultaneous dispatch dest=9 tag=5 -> all entries incl. reg 9 read tag 0.
REQ-023 Dispatch dest=0 tag=4 -> lookup rs1=0 stays tag 0, ready 0.
